rram_nand_ctrl: RTL and testbench

RRAM_NAND_CTRL -- requirements
Module: rram_nand_ctrl

---
 rtl/rram_nand_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_rram_nand_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rram_nand_ctrl.sv
// NAND-style host front end for a serial RRAM page array: command/address latch, page read and program.
// Define RRAM_PARITY_EN to append and check an even-parity bit on every array page transfer.
module rram_nand_ctrl #(
  parameter int IO_W      = 4,
  parameter int ADDR_CYC  = 3,
  parameter int BLK_AW    = 2,
  parameter int ROW_AW    = 5,
  parameter int COL_AW    = 5,
  parameter int PAGE_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IO_W-1:0]        IO,
  input  logic                   CE,
  input  logic                   ALE,
  input  logic                   CLE,
  input  logic                   WE,
  input  logic                   RE,
  inout  wire                    Dinout,
  output logic                   RB,
  inout  wire                    rram_data,
  output logic                   rram_ce,
  output logic                   rram_we,
  output logic                   rram_re,
  output logic [2**BLK_AW-1:0]   dout_block,
  output logic [2**ROW_AW-1:0]   dout_row,
  output logic [2**COL_AW-1:0]   dout_column,
  output logic                   par_err
);

  localparam int CW = $clog2(PAGE_BITS + 1);
  localparam int AW = IO_W * ADDR_CYC;
  localparam int NW = $clog2(ADDR_CYC + 1);
  localparam logic [CW-1:0] LAST   = CW'(PAGE_BITS - 1);
  localparam logic [CW-1:0] PB_CNT = CW'(PAGE_BITS);
  localparam logic [NW-1:0] NIB_LAST = NW'(ADDR_CYC - 1);
  localparam logic [2**BLK_AW-1:0] BLK_ONE = 1;
  localparam logic [2**ROW_AW-1:0] ROW_ONE = 1;
  localparam logic [2**COL_AW-1:0] COL_ONE = 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, ARRAY_RD, DATA_OUT, DATA_IN, ARRAY_WR} state_t;

  state_t               state;
  logic                 we_q, re_q, op_prog;
  logic [AW-1:0]        addr, addr_next;
  logic [NW-1:0]        nib;
  logic [PAGE_BITS-1:0] page;
  logic [CW-1:0]        cnt;
  logic                 wr_bit;

  wire we_rise    = WE & ~we_q;
  wire re_rise    = RE & ~re_q;
  wire busy       = (state == ARRAY_RD) || (state == ARRAY_WR);
  wire cmd_strobe = !CE && !busy && we_rise && CLE && !ALE;
  wire adr_strobe = !CE && !busy && we_rise && ALE && !CLE;
  wire dat_strobe = !CE && !busy && we_rise && !ALE && !CLE;

  always_comb begin
    addr_next = addr;
    addr_next[int'(nib)*IO_W +: IO_W] = IO;
  end

`ifdef RRAM_PARITY_EN
  logic par_q, wr_par;
  assign par_err = par_q;
  assign wr_bit  = (cnt == PB_CNT) ? wr_par : page[PAGE_BITS-1];
`else
  assign par_err = 1'b0;
  assign wr_bit  = page[PAGE_BITS-1];
`endif

  assign Dinout    = (state == DATA_OUT && !CE) ? page[PAGE_BITS-1] : 1'bz;
  assign rram_data = (state == ARRAY_WR) ? wr_bit : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      op_prog     <= 1'b0;
      addr        <= '0;
      nib         <= '0;
      page        <= '0;
      cnt         <= '0;
      RB          <= 1'b1;
      rram_ce     <= 1'b0;
      rram_we     <= 1'b0;
      rram_re     <= 1'b0;
      dout_block  <= BLK_ONE;
      dout_row    <= ROW_ONE;
      dout_column <= COL_ONE;
`ifdef RRAM_PARITY_EN
      par_q       <= 1'b0;
      wr_par      <= 1'b0;
`endif
    end else begin
      we_q <= WE;
      re_q <= RE;
      // Chip deselect wins over everything, including array transfers in flight.
      if (CE && state != IDLE) begin
        state   <= IDLE;
        RB      <= 1'b1;
        rram_ce <= 1'b0;
        rram_we <= 1'b0;
        rram_re <= 1'b0;
        cnt     <= '0;
        nib     <= '0;
      end else if (cmd_strobe && (IO == IO_W'(4'hF))) begin
        state   <= IDLE;
        op_prog <= 1'b0;
        addr    <= '0;
        nib     <= '0;
        cnt     <= '0;
      end else if (cmd_strobe && (IO == IO_W'(1) || IO == IO_W'(2))) begin
        state   <= CMD;
        op_prog <= (IO == IO_W'(2));
        nib     <= '0;
        cnt     <= '0;
`ifdef RRAM_PARITY_EN
        if (IO == IO_W'(1)) par_q <= 1'b0;
`endif
      end else begin
        case (state)
          CMD, ADDR: begin
            if (adr_strobe) begin
              addr <= addr_next;
              if (nib == NIB_LAST) begin
                nib         <= '0;
                cnt         <= '0;
                dout_column <= COL_ONE << addr_next[COL_AW-1:0];
                dout_row    <= ROW_ONE << addr_next[COL_AW +: ROW_AW];
                dout_block  <= BLK_ONE << addr_next[COL_AW+ROW_AW +: BLK_AW];
                if (op_prog) begin
                  state <= DATA_IN;
                end else begin
                  state   <= ARRAY_RD;
                  RB      <= 1'b0;
                  rram_ce <= 1'b1;
                  rram_re <= 1'b1;
                end
              end else begin
                nib   <= nib + 1'b1;
                state <= ADDR;
              end
            end
          end
          ARRAY_RD: begin
`ifdef RRAM_PARITY_EN
            if (cnt == PB_CNT) begin
              par_q   <= ^page ^ rram_data;
              state   <= DATA_OUT;
              RB      <= 1'b1;
              rram_ce <= 1'b0;
              rram_re <= 1'b0;
              cnt     <= '0;
            end else begin
              page <= {page[PAGE_BITS-2:0], rram_data};
              cnt  <= cnt + 1'b1;
            end
`else
            page <= {page[PAGE_BITS-2:0], rram_data};
            if (cnt == LAST) begin
              state   <= DATA_OUT;
              RB      <= 1'b1;
              rram_ce <= 1'b0;
              rram_re <= 1'b0;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
`endif
          end
          DATA_OUT: begin
            if (re_rise) begin
              page <= {page[PAGE_BITS-2:0], 1'b0};
              if (cnt == LAST) begin
                state <= IDLE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          DATA_IN: begin
            if (dat_strobe) begin
              page <= {page[PAGE_BITS-2:0], Dinout};
              if (cnt == LAST) begin
                state   <= ARRAY_WR;
                RB      <= 1'b0;
                rram_ce <= 1'b1;
                rram_we <= 1'b1;
                cnt     <= '0;
`ifdef RRAM_PARITY_EN
                wr_par  <= ^{page[PAGE_BITS-2:0], Dinout};
`endif
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          ARRAY_WR: begin
`ifdef RRAM_PARITY_EN
            if (cnt == PB_CNT) begin
`else
            if (cnt == LAST) begin
`endif
              state   <= IDLE;
              RB      <= 1'b1;
              rram_ce <= 1'b0;
              rram_we <= 1'b0;
              cnt     <= '0;
            end else begin
              page <= {page[PAGE_BITS-2:0], 1'b0};
              cnt  <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rram_nand_ctrl.sv
// Scoreboard bench for rram_nand_ctrl: read, program, abort, async reset and ignored-strobe cases.
// Define RRAM_PARITY_EN for both files to exercise the parity build.
module tb_rram_nand_ctrl;

  localparam int PB = 32;
`ifdef RRAM_PARITY_EN
  localparam int NB = PB + 1;
`else
  localparam int NB = PB;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  IO = '0;
  logic        CE = 1'b1, ALE = 1'b0, CLE = 1'b0, WE = 1'b0, RE = 1'b0;
  wire         Dinout, rram_data;
  logic        RB, rram_ce, rram_we, rram_re, par_err;
  logic [3:0]  dout_block;
  logic [31:0] dout_row, dout_column;

  logic din_en = 1'b0, din_bit = 1'b0;
  logic rd_en = 1'b0, rd_bit = 1'b0;
  assign Dinout    = din_en ? din_bit : 1'bz;
  assign rram_data = rd_en ? rd_bit : 1'bz;
  pullup (Dinout);
  pullup (rram_data);

  rram_nand_ctrl dut (
    .clk(clk), .rst_n(rst_n), .IO(IO), .CE(CE), .ALE(ALE), .CLE(CLE), .WE(WE), .RE(RE),
    .Dinout(Dinout), .RB(RB), .rram_data(rram_data), .rram_ce(rram_ce), .rram_we(rram_we),
    .rram_re(rram_re), .dout_block(dout_block), .dout_row(dout_row), .dout_column(dout_column),
    .par_err(par_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic exp_rd[$];
  logic exp_wr[$];
  bit   out_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Array model: serves rd_vec MSB-first while the DUT requests a read.
  logic [32:0] rd_vec = '0;
  int          rd_len = NB;
  int          rd_idx = 0;
  always @(negedge clk) begin
    if (rram_re && rd_idx < rd_len) begin
      rd_en  = 1'b1;
      rd_bit = rd_vec[rd_len-1-rd_idx];
      rd_idx++;
    end else begin
      rd_en = 1'b0;
      if (!rram_re) rd_idx = 0;
    end
  end

  always @(posedge RE) begin
    if (out_phase) begin
      if (exp_rd.size() == 0) check("dinout_queue_empty", 1, 0);
      else check("dinout_bit", Dinout, exp_rd.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rram_we) begin
      if (exp_wr.size() == 0) check("rram_wr_queue_empty", 1, 0);
      else check("rram_wr_bit", rram_data, exp_wr.pop_front());
    end
  end

  task automatic we_pulse();
    @(negedge clk) WE = 1'b1;
    @(negedge clk) WE = 1'b0;
  endtask

  task automatic re_pulse();
    @(negedge clk) RE = 1'b1;
    @(negedge clk) RE = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] c);
    CLE = 1'b1; IO = c;
    we_pulse();
    CLE = 1'b0;
  endtask

  task automatic addr3(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    ALE = 1'b1;
    IO = a0; we_pulse();
    IO = a1; we_pulse();
    IO = a2; we_pulse();
    ALE = 1'b0;
  endtask

  task automatic wait_rb_high(output int n);
    n = 0;
    while (RB === 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic load_rd(input logic [31:0] d, input logic p);
    if (NB > PB) rd_vec = {d, p};
    else rd_vec = {1'b0, d};
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rdat, wdat;
    int n;
    rdat = 32'hB529_524A;
    wdat = 32'hA5A5_0F0F;

    @(negedge clk);
    check("rst_rb", RB, 1);
    check("rst_rram_ce", rram_ce, 0);
    check("rst_rram_we", rram_we, 0);
    check("rst_rram_re", rram_re, 0);
    check("rst_par_err", par_err, 0);
    check("rst_column", dout_column, 32'h1);
    check("rst_row", dout_row, 32'h1);
    check("rst_block", dout_block, 4'h1);
    check("rst_dinout_z", Dinout, 1);
    check("rst_rram_data_z", rram_data, 1);
    rst_n = 1'b1;
    @(negedge clk) CE = 1'b0;

    // unknown command, then address nibbles with no operation pending
    cmd(4'h7);
    addr3(4'h1, 4'h2, 4'h3);
    repeat (3) @(negedge clk);
    check("ign_rb", RB, 1);
    check("ign_rram_ce", rram_ce, 0);
    check("ign_column", dout_column, 32'h1);
    check("ign_row", dout_row, 32'h1);

    // page read; ALE=CLE=1 strobe and an RE strobe while busy must be ignored
    load_rd(rdat, ^rdat);
    cmd(4'h1);
    ALE = 1'b1; CLE = 1'b1; IO = 4'h9;
    we_pulse();
    ALE = 1'b0; CLE = 1'b0;
    addr3(4'h0, 4'h8, 4'h1);
    check("rd_rram_ce", rram_ce, 1);
    check("rd_rram_re", rram_re, 1);
    n = 0;
    while (RB === 1'b0 && n < 200) begin
      n++;
      if (n == 5) RE = 1'b1;
      if (n == 7) RE = 1'b0;
      @(negedge clk);
    end
    check("rd_rb_low_clks", n, NB);
    check("rd_column", dout_column, 32'h1);
    check("rd_row", dout_row, 32'h1 << 12);
    check("rd_block", dout_block, 4'h1);
    check("rd_rram_ce_done", rram_ce, 0);
    check("rd_par_err", par_err, 0);
    for (int i = 0; i < PB; i++) exp_rd.push_back(rdat[PB-1-i]);
    out_phase = 1'b1;
    repeat (PB) re_pulse();
    out_phase = 1'b0;
    check("rd_queue_drained", exp_rd.size(), 0);
    check("rd_dinout_released", Dinout, 1);

    // program, preceded by a partial address cleared by the reset command
    cmd(4'h1);
    ALE = 1'b1; IO = 4'h3; we_pulse(); ALE = 1'b0;
    cmd(4'hF);
    cmd(4'h2);
    addr3(4'h5, 4'h8, 4'h0);
    check("wr_column", dout_column, 32'h1 << 5);
    check("wr_row", dout_row, 32'h1 << 4);
    check("wr_block", dout_block, 4'h1);
    check("wr_rb_data_in", RB, 1);
    for (int i = 0; i < PB; i++) exp_wr.push_back(wdat[PB-1-i]);
    if (NB > PB) exp_wr.push_back(^wdat);
    din_en = 1'b1;
    for (int i = 0; i < PB; i++) begin
      din_bit = wdat[PB-1-i];
      we_pulse();
    end
    din_en = 1'b0;
    n = 0;
    while (rram_we === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("wr_we_high_clks", n, NB);
    check("wr_rb_after", RB, 1);
    check("wr_rram_ce_after", rram_ce, 0);
    check("wr_rram_data_released", rram_data, 1);
    check("wr_queue_drained", exp_wr.size(), 0);

    // abort a read after 10 array bits
    cmd(4'h1);
    addr3(4'h0, 4'h0, 4'h0);
    repeat (10) @(negedge clk);
    check("abort_busy_before", RB, 0);
    CE = 1'b1;
    @(negedge clk);
    check("abort_rram_ce", rram_ce, 0);
    check("abort_rram_re", rram_re, 0);
    check("abort_rb", RB, 1);
    check("abort_column", dout_column, 32'h1);
    CE = 1'b0;
    @(negedge clk);

    // asynchronous reset in the middle of DATA_OUT
    load_rd(rdat, ^rdat);
    cmd(4'h1);
    addr3(4'h0, 4'h8, 4'h1);
    wait_rb_high(n);
    re_pulse();
    check("ars_dinout_driven", Dinout, rdat[30]);
    #2 rst_n = 1'b0;
    #1;
    check("ars_rb", RB, 1);
    check("ars_rram_ce", rram_ce, 0);
    check("ars_rram_re", rram_re, 0);
    check("ars_rram_we", rram_we, 0);
    check("ars_par_err", par_err, 0);
    check("ars_column", dout_column, 32'h1);
    check("ars_row", dout_row, 32'h1);
    check("ars_block", dout_block, 4'h1);
    check("ars_dinout_z", Dinout, 1);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

`ifdef RRAM_PARITY_EN
    load_rd(32'h0000_0001, 1'b0);
    cmd(4'h1);
    addr3(4'h0, 4'h0, 4'h0);
    wait_rb_high(n);
    check("par_bad_err", par_err, 1);
    repeat (PB) re_pulse();
    load_rd(32'h0000_0001, 1'b1);
    cmd(4'h1);
    check("par_clear_on_cmd", par_err, 0);
    addr3(4'h0, 4'h0, 4'h0);
    wait_rb_high(n);
    check("par_good_err", par_err, 0);
    repeat (PB) re_pulse();
`else
    check("par_err_tied", par_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
